// File: rtl/sp_unit_param.sv
// Stack-pointer unit: INC/DEC/REL arithmetic, byte-beat LOAD, and multi-byte PUSH/POP address sequencing.
// Optional macro SP_LIMIT_EN adds limit_lo/limit_hi bounds checking on PUSH/POP with a fault pulse.
module sp_unit_param #(
  parameter int                ADDR_W     = 16,
  parameter int                BYTE_W     = 8,
  parameter int                WORD_BYTES = 2,
  parameter int                STEP       = 1,
  parameter logic [ADDR_W-1:0] RESET_VAL  = 16'hFFFE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        op,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        src_sel,
  input  logic [BYTE_W-1:0] data_bus,
  input  logic [BYTE_W-1:0] alu_in,
  input  logic [BYTE_W-1:0] reg_file_out2,
  input  logic              byte_valid,
  input  logic              load_abort,
`ifdef SP_LIMIT_EN
  input  logic [ADDR_W-1:0] limit_lo,
  input  logic [ADDR_W-1:0] limit_hi,
  output logic              fault,
`endif
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_valid,
  output logic              done,
  output logic              rel_h,
  output logic              rel_c
);

  // state  | meaning
  // S_IDLE | waiting for an op; INC/DEC/REL complete here in one edge
  // S_LOAD | collecting SP bytes; cnt==NB is the post-done tail cycle
  // S_PUSH | pre-decrement beats; cnt==WORD_BYTES is the post-done tail cycle
  // S_POP  | post-increment beats; same tail handling as S_PUSH
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PUSH, S_POP} state_t;

  localparam int NB      = ADDR_W / BYTE_W;
  localparam int CNT_MAX = (NB > WORD_BYTES) ? NB : WORD_BYTES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   temp;
  logic [BYTE_W-1:0]   b_sel;
  logic [ADDR_W-1:0]   load_word;
  logic [ADDR_W-1:0]   rel_ext;
  logic [BYTE_W:0]     rel_sum;
  logic [4:0]          rel_nib;
  logic                push_reject;
  logic                pop_reject;

  assign op_ready = (state == S_IDLE);

  always_comb begin
    case (src_sel)
      2'd1:    b_sel = alu_in;
      2'd2:    b_sel = reg_file_out2;
      default: b_sel = data_bus;
    endcase
  end

  // Current beat merged into the buffered slots; on the final beat this is the new SP.
  always_comb begin
    load_word = temp;
    for (int i = 0; i < NB; i++) begin
      if (cnt == CNT_W'(i)) load_word[i*BYTE_W +: BYTE_W] = b_sel;
    end
  end

  assign rel_ext = ADDR_W'($signed(b_sel));
  assign rel_sum = {1'b0, sp[BYTE_W-1:0]} + {1'b0, b_sel};
  assign rel_nib = {1'b0, sp[3:0]} + {1'b0, b_sel[3:0]};

`ifdef SP_LIMIT_EN
  logic [ADDR_W:0] push_low;
  logic [ADDR_W:0] pop_high;
  // Extra top bit catches the borrow/carry so a wrapped address counts as a violation.
  assign push_low    = {1'b0, sp} - (ADDR_W+1)'(WORD_BYTES);
  assign pop_high    = {1'b0, sp} + (ADDR_W+1)'(WORD_BYTES - 1);
  assign push_reject = push_low[ADDR_W] || (push_low[ADDR_W-1:0] < limit_lo);
  assign pop_reject  = (pop_high > {1'b0, limit_hi});
`else
  assign push_reject = 1'b0;
  assign pop_reject  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sp        <= RESET_VAL;
      temp      <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_valid <= 1'b0;
      done      <= 1'b0;
      rel_h     <= 1'b0;
      rel_c     <= 1'b0;
`ifdef SP_LIMIT_EN
      fault     <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      mem_valid <= 1'b0;
`ifdef SP_LIMIT_EN
      fault     <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            case (op)
              3'd1: sp <= sp + ADDR_W'(STEP);
              3'd2: sp <= sp - ADDR_W'(STEP);
              3'd3: begin
                state <= S_LOAD;
                cnt   <= '0;
              end
              3'd4: begin
                sp    <= sp + rel_ext;
                rel_c <= rel_sum[BYTE_W];
                rel_h <= rel_nib[4];
              end
              3'd5: begin
                if (push_reject) begin
`ifdef SP_LIMIT_EN
                  fault <= 1'b1;
`endif
                end else begin
                  sp        <= sp - 1'b1;
                  mem_addr  <= sp - 1'b1;
                  mem_valid <= 1'b1;
                  cnt       <= CNT_W'(1);
                  done      <= (WORD_BYTES == 1);
                  state     <= S_PUSH;
                end
              end
              3'd6: begin
                if (pop_reject) begin
`ifdef SP_LIMIT_EN
                  fault <= 1'b1;
`endif
                end else begin
                  sp        <= sp + 1'b1;
                  mem_addr  <= sp;
                  mem_valid <= 1'b1;
                  cnt       <= CNT_W'(1);
                  done      <= (WORD_BYTES == 1);
                  state     <= S_POP;
                end
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (cnt == CNT_W'(NB) || load_abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (byte_valid) begin
            temp <= load_word;
            cnt  <= cnt + 1'b1;
            if (cnt == CNT_W'(NB - 1)) begin
              sp   <= load_word;
              done <= 1'b1;
            end
          end
        end
        S_PUSH, S_POP: begin
          if (cnt == CNT_W'(WORD_BYTES)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            mem_valid <= 1'b1;
            cnt       <= cnt + 1'b1;
            done      <= (cnt == CNT_W'(WORD_BYTES - 1));
            if (state == S_PUSH) begin
              sp       <= sp - 1'b1;
              mem_addr <= sp - 1'b1;
            end else begin
              sp       <= sp + 1'b1;
              mem_addr <= sp;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_unit_param.sv
// Directed bench for sp_unit_param (default parameters); define SP_LIMIT_EN to also cover the limit check.
module tb_sp_unit_param;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  src_sel = 2'd0;
  logic [7:0]  data_bus = 8'h00, alu_in = 8'h00, reg_file_out2 = 8'h00;
  logic        byte_valid = 1'b0;
  logic        load_abort = 1'b0;
  logic [15:0] sp, mem_addr;
  logic        mem_valid, done, rel_h, rel_c;
`ifdef SP_LIMIT_EN
  logic [15:0] limit_lo = 16'h0000;
  logic [15:0] limit_hi = 16'hFFFF;
  logic        fault;
`endif

  int checks = 0;
  int failures = 0;

  sp_unit_param dut (
    .clock(clock), .reset(reset), .op(op), .op_valid(op_valid), .op_ready(op_ready),
    .src_sel(src_sel), .data_bus(data_bus), .alu_in(alu_in), .reg_file_out2(reg_file_out2),
    .byte_valid(byte_valid), .load_abort(load_abort),
`ifdef SP_LIMIT_EN
    .limit_lo(limit_lo), .limit_hi(limit_hi), .fault(fault),
`endif
    .sp(sp), .mem_addr(mem_addr), .mem_valid(mem_valid), .done(done),
    .rel_h(rel_h), .rel_c(rel_c)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] o);
    op = o; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
  endtask

  // Loads a 16-bit SP value via two alu_in beats, then waits out the tail cycle.
  task automatic do_load(input logic [15:0] v);
    src_sel = 2'd1;
    issue(3'd3);
    alu_in = v[7:0]; byte_valid = 1'b1; step();
    alu_in = v[15:8]; step();
    byte_valid = 1'b0; step();
  endtask

  task automatic test_reset();
    step(); step();
    reset = 1'b1;
    step();
    checks++; if (sp !== 16'hFFFE) begin failures++; $display("FAIL reset_sp got=%h exp=fffe", sp); end
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", op_ready); end
    checks++; if (mem_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_valid_done got=%b%b exp=00", mem_valid, done); end
    checks++; if (rel_h !== 1'b0 || rel_c !== 1'b0 || mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_flags_addr got=%b%b %h exp=00 0000", rel_h, rel_c, mem_addr); end
  endtask

  task automatic test_load();
    src_sel = 2'd0;
    issue(3'd3);
    checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL load_ready_accept got=%b exp=0", op_ready); end
    data_bus = 8'h34; byte_valid = 1'b1; step(); byte_valid = 1'b0;
    checks++; if (sp !== 16'hFFFE || done !== 1'b0) begin failures++; $display("FAIL load_beat1 sp=%h done=%b exp=fffe 0", sp, done); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (op_ready !== 1'b0 || sp !== 16'hFFFE || done !== 1'b0) begin failures++; $display("FAIL load_gap%0d ready=%b sp=%h done=%b exp=0 fffe 0", i, op_ready, sp, done); end
    end
    data_bus = 8'h12; byte_valid = 1'b1; step(); byte_valid = 1'b0;
    checks++; if (sp !== 16'h1234 || done !== 1'b1 || op_ready !== 1'b0) begin failures++; $display("FAIL load_final sp=%h done=%b ready=%b exp=1234 1 0", sp, done, op_ready); end
    step();
    checks++; if (done !== 1'b0 || op_ready !== 1'b1 || sp !== 16'h1234) begin failures++; $display("FAIL load_tail done=%b ready=%b sp=%h exp=0 1 1234", done, op_ready, sp); end
  endtask

  task automatic test_inc_dec();
    issue(3'd1);
    checks++; if (sp !== 16'h1235 || op_ready !== 1'b1) begin failures++; $display("FAIL inc sp=%h ready=%b exp=1235 1", sp, op_ready); end
    issue(3'd2);
    checks++; if (sp !== 16'h1234) begin failures++; $display("FAIL dec sp=%h exp=1234", sp); end
    op = 3'd1; op_valid = 1'b1;
    step(); step(); step();
    op_valid = 1'b0;
    checks++; if (sp !== 16'h1237) begin failures++; $display("FAIL inc_back_to_back sp=%h exp=1237", sp); end
    issue(3'd7);
    issue(3'd0);
    checks++; if (sp !== 16'h1237 || op_ready !== 1'b1) begin failures++; $display("FAIL nop_reserved sp=%h ready=%b exp=1237 1", sp, op_ready); end
  endtask

  task automatic test_rel();
    do_load(16'hFFF8);
    src_sel = 2'd2; reg_file_out2 = 8'h08;
    issue(3'd4);
    checks++; if (sp !== 16'h0000 || rel_c !== 1'b1 || rel_h !== 1'b1) begin failures++; $display("FAIL rel_wrap sp=%h c=%b h=%b exp=0000 1 1", sp, rel_c, rel_h); end
    issue(3'd1);
    checks++; if (rel_c !== 1'b1 || rel_h !== 1'b1) begin failures++; $display("FAIL rel_flags_hold c=%b h=%b exp=1 1", rel_c, rel_h); end
    do_load(16'h1000);
    src_sel = 2'd3; data_bus = 8'h80;
    issue(3'd4);
    checks++; if (sp !== 16'h0F80 || rel_c !== 1'b0 || rel_h !== 1'b0) begin failures++; $display("FAIL rel_neg sp=%h c=%b h=%b exp=0f80 0 0", sp, rel_c, rel_h); end
  endtask

  task automatic test_push();
    do_load(16'hD000);
    op = 3'd5; op_valid = 1'b1;
    step();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 16'hCFFF || done !== 1'b0 || op_ready !== 1'b0) begin failures++; $display("FAIL push_beat1 v=%b a=%h d=%b r=%b exp=1 cfff 0 0", mem_valid, mem_addr, done, op_ready); end
    step();
    op_valid = 1'b0;
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 16'hCFFE || done !== 1'b1 || sp !== 16'hCFFE) begin failures++; $display("FAIL push_beat2 v=%b a=%h d=%b sp=%h exp=1 cffe 1 cffe", mem_valid, mem_addr, done, sp); end
    step();
    checks++; if (mem_valid !== 1'b0 || done !== 1'b0 || op_ready !== 1'b1 || sp !== 16'hCFFE) begin failures++; $display("FAIL push_end v=%b d=%b r=%b sp=%h exp=0 0 1 cffe", mem_valid, done, op_ready, sp); end
`ifndef SP_LIMIT_EN
    do_load(16'h0001);
    issue(3'd5);
    checks++; if (mem_addr !== 16'h0000 || mem_valid !== 1'b1) begin failures++; $display("FAIL push_wrap1 a=%h v=%b exp=0000 1", mem_addr, mem_valid); end
    step();
    checks++; if (mem_addr !== 16'hFFFF || sp !== 16'hFFFF || done !== 1'b1) begin failures++; $display("FAIL push_wrap2 a=%h sp=%h d=%b exp=ffff ffff 1", mem_addr, sp, done); end
    step();
`endif
  endtask

  task automatic test_pop();
    do_load(16'hFFFE);
    issue(3'd6);
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 16'hFFFE || done !== 1'b0) begin failures++; $display("FAIL pop_beat1 v=%b a=%h d=%b exp=1 fffe 0", mem_valid, mem_addr, done); end
    step();
    checks++; if (mem_addr !== 16'hFFFF || sp !== 16'h0000 || done !== 1'b1) begin failures++; $display("FAIL pop_beat2 a=%h sp=%h d=%b exp=ffff 0000 1", mem_addr, sp, done); end
    step();
    checks++; if (op_ready !== 1'b1 || mem_valid !== 1'b0) begin failures++; $display("FAIL pop_end r=%b v=%b exp=1 0", op_ready, mem_valid); end
  endtask

  task automatic test_abort();
    do_load(16'h4321);
    src_sel = 2'd0;
    issue(3'd3);
    data_bus = 8'h55; byte_valid = 1'b1; step();
    data_bus = 8'h66; load_abort = 1'b1; step();
    byte_valid = 1'b0; load_abort = 1'b0;
    checks++; if (op_ready !== 1'b1 || sp !== 16'h4321 || done !== 1'b0) begin failures++; $display("FAIL abort r=%b sp=%h d=%b exp=1 4321 0", op_ready, sp, done); end
    step();
    checks++; if (done !== 1'b0 || sp !== 16'h4321) begin failures++; $display("FAIL abort_after d=%b sp=%h exp=0 4321", done, sp); end
  endtask

  task automatic test_reset_mid_push();
    do_load(16'h8000);
    issue(3'd5);
    checks++; if (op_ready !== 1'b0 || mem_valid !== 1'b1) begin failures++; $display("FAIL midpush_active r=%b v=%b exp=0 1", op_ready, mem_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (sp !== 16'hFFFE || op_ready !== 1'b1 || mem_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_reset sp=%h r=%b v=%b d=%b exp=fffe 1 0 0", sp, op_ready, mem_valid, done); end
    #2 reset = 1'b1;
    step();
    checks++; if (sp !== 16'hFFFE || op_ready !== 1'b1) begin failures++; $display("FAIL after_reset sp=%h r=%b exp=fffe 1", sp, op_ready); end
  endtask

`ifdef SP_LIMIT_EN
  task automatic test_limit();
    do_load(16'hC001);
    limit_lo = 16'hC000;
    issue(3'd5);
    checks++; if (fault !== 1'b1 || sp !== 16'hC001 || mem_valid !== 1'b0 || op_ready !== 1'b1) begin failures++; $display("FAIL limit_push f=%b sp=%h v=%b r=%b exp=1 c001 0 1", fault, sp, mem_valid, op_ready); end
    step();
    checks++; if (fault !== 1'b0 || mem_valid !== 1'b0 || sp !== 16'hC001) begin failures++; $display("FAIL limit_after f=%b v=%b sp=%h exp=0 0 c001", fault, mem_valid, sp); end
    limit_lo = 16'h0000;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout time=%0t limit=1000000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_inc_dec();
    test_rel();
    test_push();
    test_pop();
    test_abort();
`ifdef SP_LIMIT_EN
    test_limit();
`endif
    test_reset_mid_push();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sp_unit_param.md
Name: sp_unit_param

Overview:
- Parametrised stack-pointer unit for the CPU datapath.
- Holds SP and supports increment, decrement, and signed-relative add with H/C flags.
- Assembles SP from ADDR_W/BYTE_W byte beats.
- Sequences multi-byte PUSH/POP by emitting one memory address per cycle.
- Sits between the control unit (op handshake), the byte sources (data bus, ALU, register file) and the memory address mux.

Parameters:
- ADDR_W, 16, SP width; must be a multiple of BYTE_W.
- BYTE_W, 8, width of the byte sources and of the relative offset.
- WORD_BYTES, 2, bytes per PUSH/POP sequence (1..8).
- STEP, 1, INC/DEC amount.
- RESET_VAL, 16'hFFFE, SP value after reset.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  3  0 NOP, 1 INC, 2 DEC, 3 LOAD, 4 REL, 5 PUSH, 6 POP, 7 reserved (treated as NOP)
- op_valid  in  1  op request
- op_ready  out  1  high only in IDLE
- src_sel  in  2  byte source: 0 data_bus, 1 alu_in, 2 reg_file_out2, 3 data_bus
- data_bus, alu_in, reg_file_out2  in  BYTE_W each  byte sources
- byte_valid  in  1  LOAD beat strobe
- load_abort  in  1  abandon LOAD
- sp  out  ADDR_W  current SP (registered)
- mem_addr  out  ADDR_W  PUSH/POP beat address (registered)
- mem_valid  out  1  mem_addr valid this cycle
- done  out  1  one-cycle pulse when a LOAD/PUSH/POP completes
- rel_h, rel_c  out  1  flags from the last REL (registered)

Behaviour:
- Reset (asynchronous, any state): sp=RESET_VAL, state=IDLE, temp buffer=0, beat counter=0, mem_addr=0, mem_valid=0, done=0, rel_h=0, rel_c=0.
- An op is accepted on op_valid & op_ready. While op_ready=0, op_valid is ignored and no op is queued.
- Selected byte: B = mux(src_sel).
- Width rule: all SP arithmetic is modulo 2^ADDR_W and wraps silently.
- INC/DEC: sp <= sp ± STEP on the edge that accepts the op; stays in IDLE; op_ready remains high.
- REL: sp <= sp + sign_extend(B) in one cycle.
  - rel_c = carry out of bit BYTE_W-1 of the unsigned add of sp[BYTE_W-1:0] + B.
  - rel_h = carry out of bit 3 of the same add.
  - Flags hold until the next REL.
- LOAD: IDLE -> LOAD, beat counter cleared.
  - Each byte_valid writes B into temp byte slot[cnt], low byte first.
  - On beat NB = ADDR_W/BYTE_W, sp <= {B, temp slots} atomically, done pulses, state -> IDLE.
  - sp is unchanged throughout the LOAD.
  - load_abort returns to IDLE with sp unchanged and no done pulse; abort wins over a simultaneous byte_valid.
- PUSH: IDLE -> PUSH for WORD_BYTES cycles (pre-decrement).
  - Each cycle: sp <= sp-1, mem_addr <= sp-1, mem_valid=1.
  - done pulses on the cycle the final address is presented; then IDLE.
- POP: IDLE -> POP for WORD_BYTES cycles (post-increment).
  - Each cycle: mem_addr <= sp, sp <= sp+1, mem_valid=1.
  - done pulses with the final address; then IDLE.
- mem_valid is 0 in IDLE and LOAD.
- Latency:
  - INC/DEC/REL visible on sp one edge after acceptance.
  - First PUSH/POP address is valid the cycle after acceptance.
  - op_ready returns high the cycle after done.
- Wrap-around: a POP from 0xFFFE (ADDR_W=16, WORD_BYTES=2) emits 0xFFFE, 0xFFFF and leaves sp=0x0000. PUSH wraps symmetrically.

Optional Feature:
- Macro: SP_LIMIT_EN.
- When defined, adds inputs limit_lo and limit_hi (ADDR_W each) and output fault (1).
- PUSH is rejected if sp - WORD_BYTES < limit_lo, computed unsigned with the wrap detected as a violation.
- POP is rejected if sp + WORD_BYTES - 1 > limit_hi.
- On rejection: the op is consumed, sp is unchanged, mem_valid stays 0, fault pulses for one cycle, and the unit stays in IDLE.
- INC/DEC/REL/LOAD are unchecked.
- When the macro is undefined: no limit ports, no fault port, and no checks.

Test Plan:
- Reset deasserted -> sp=0xFFFE, op_ready=1, mem_valid=0; assert reset mid-PUSH -> sp=0xFFFE and IDLE immediately, without waiting for a clock.
- LOAD with src_sel=0, beats 0x34 then 0x12 with a 3-cycle gap -> op_ready=0 throughout, sp unchanged until the second beat, then sp=0x1234 and done=1 for one cycle.
- REL from sp=0xFFF8 with B=0x08 -> sp=0x0000, rel_c=1, rel_h=1; REL from sp=0x1000 with B=0x80 -> sp=0x0F80, rel_c=0, rel_h=0.
- PUSH from sp=0xD000 -> mem_addr 0xCFFF then 0xCFFE on consecutive cycles, done on the second, sp=0xCFFE; op_valid held high during the sequence is ignored.
- POP from sp=0xFFFE -> mem_addr 0xFFFE, 0xFFFF, sp=0x0000; LOAD after one beat followed by load_abort -> sp unchanged, no done.
- SP_LIMIT_EN with limit_lo=0xC000 and sp=0xC001, issue PUSH -> fault pulses, sp=0xC001, mem_valid stays 0.
